qu_instr_decoder: RTL and testbench



---
 rtl/qu_instr_decoder_pkg.sv | 52 +++++
 rtl/qu_instr_decode_comb.sv | 199 +++++++++++++++++++
 rtl/qu_instr_decoder.sv | 106 ++++++++++
 tb/tb_qu_instr_decoder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qu_instr_decoder_pkg.sv
// rtl/qu_instr_decoder_pkg.sv - shared types and constants for the Qu instruction decoder
// Contents: PC/instruction widths, RV32I major opcodes, dec_optype_t class codes,
//           dec_bundle_t (all decoded fields presented on the decoder outputs).
package qu_instr_decoder_pkg;

    localparam int QU_PC_WIDTH    = 12;
    localparam int QU_INSTR_WIDTH = 32;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef enum logic [3:0] {
        DEC_R       = 4'd0,
        DEC_I       = 4'd1,
        DEC_LOAD    = 4'd2,
        DEC_STORE   = 4'd3,
        DEC_BRANCH  = 4'd4,
        DEC_JAL     = 4'd5,
        DEC_JALR    = 4'd6,
        DEC_LUI     = 4'd7,
        DEC_AUIPC   = 4'd8,
        DEC_SYSTEM  = 4'd9,
        DEC_CSR     = 4'd10,
        DEC_FENCE   = 4'd11,
        DEC_ILLEGAL = 4'd15
    } dec_optype_t;

    typedef struct packed {
        dec_optype_t optype;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rd_valid;
        logic        rs1_valid;
        logic        rs2_valid;
        logic        imm_valid;
        logic [31:0] imm;
        logic        illegal;
    } dec_bundle_t;

endpackage

// File: rtl/qu_instr_decode_comb.sv
// rtl/qu_instr_decode_comb.sv - combinational RV32I instruction word to dec_bundle_t decode
// Ports: i_instr  in  32  raw instruction word
//        o_bundle out     decoded class, register fields, validity bits, immediate, illegal flag
import qu_instr_decoder_pkg::*;

module qu_instr_decode_comb (
    input  logic [31:0] i_instr,
    output dec_bundle_t o_bundle
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_z;

    dec_optype_t w_optype;
    logic        w_rd_valid;
    logic        w_rs1_valid;
    logic        w_rs2_valid;
    logic        w_imm_valid;
    logic [31:0] w_imm;
    logic        w_illegal;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];
    assign w_rd     = i_instr[11:7];
    assign w_rs1    = i_instr[19:15];
    assign w_rs2    = i_instr[24:20];

    assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'b0};
    assign w_imm_z = {20'b0, i_instr[31:20]};

    always_comb begin
        w_optype    = DEC_ILLEGAL;
        w_rd_valid  = 1'b0;
        w_rs1_valid = 1'b0;
        w_rs2_valid = 1'b0;
        w_imm_valid = 1'b0;
        w_imm       = 32'b0;
        w_illegal   = 1'b0;

        if (i_instr[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end else begin
            case (w_opcode)
                OPC_R: begin
                    w_optype    = DEC_R;
                    w_rd_valid  = 1'b1;
                    w_rs1_valid = 1'b1;
                    w_rs2_valid = 1'b1;
                    // Only base ops (funct7=0) and SUB/SRA (funct7=0x20) exist in RV32I.
                    if (!((w_funct7 == 7'h00) ||
                          (w_funct7 == 7'h20 && (w_funct3 == 3'b000 || w_funct3 == 3'b101))))
                        w_illegal = 1'b1;
                end
                OPC_I: begin
                    w_optype    = DEC_I;
                    w_rd_valid  = 1'b1;
                    w_rs1_valid = 1'b1;
                    w_imm_valid = 1'b1;
                    if (w_funct3 == 3'b001) begin
                        // SLLI: immediate is the shift amount only
                        w_imm = {27'b0, w_rs2};
                        if (w_funct7 != 7'h00)
                            w_illegal = 1'b1;
                    end else if (w_funct3 == 3'b101) begin
                        // SRLI/SRAI: funct7 selects arithmetic vs logical
                        w_imm = {27'b0, w_rs2};
                        if (w_funct7 != 7'h00 && w_funct7 != 7'h20)
                            w_illegal = 1'b1;
                    end else begin
                        w_imm = w_imm_i;
                    end
                end
                OPC_LOAD: begin
                    w_optype    = DEC_LOAD;
                    w_rd_valid  = 1'b1;
                    w_rs1_valid = 1'b1;
                    w_imm_valid = 1'b1;
                    w_imm       = w_imm_i;
                    if (w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111)
                        w_illegal = 1'b1;
                end
                OPC_STORE: begin
                    w_optype    = DEC_STORE;
                    w_rs1_valid = 1'b1;
                    w_rs2_valid = 1'b1;
                    w_imm_valid = 1'b1;
                    w_imm       = w_imm_s;
                    if (w_funct3 > 3'b010)
                        w_illegal = 1'b1;
                end
                OPC_BRANCH: begin
                    w_optype    = DEC_BRANCH;
                    w_rs1_valid = 1'b1;
                    w_rs2_valid = 1'b1;
                    w_imm_valid = 1'b1;
                    w_imm       = w_imm_b;
                    if (w_funct3 == 3'b010 || w_funct3 == 3'b011)
                        w_illegal = 1'b1;
                end
                OPC_JAL: begin
                    w_optype    = DEC_JAL;
                    w_rd_valid  = 1'b1;
                    w_imm_valid = 1'b1;
                    w_imm       = w_imm_j;
                end
                OPC_JALR: begin
                    w_optype    = DEC_JALR;
                    w_rd_valid  = 1'b1;
                    w_rs1_valid = 1'b1;
                    w_imm_valid = 1'b1;
                    w_imm       = w_imm_i;
                    if (w_funct3 != 3'b000)
                        w_illegal = 1'b1;
                end
                OPC_LUI: begin
                    w_optype    = DEC_LUI;
                    w_rd_valid  = 1'b1;
                    w_imm_valid = 1'b1;
                    w_imm       = w_imm_u;
                end
                OPC_AUIPC: begin
                    w_optype    = DEC_AUIPC;
                    w_rd_valid  = 1'b1;
                    w_imm_valid = 1'b1;
                    w_imm       = w_imm_u;
                end
                OPC_SYSTEM: begin
                    if (w_funct3 == 3'b000) begin
                        // ECALL (imm=0) / EBREAK (imm=1) only, with zero register fields
                        w_optype = DEC_SYSTEM;
                        if (i_instr[31:20] > 12'd1 || w_rd != 5'd0 || w_rs1 != 5'd0)
                            w_illegal = 1'b1;
                    end else if (w_funct3 == 3'b100) begin
                        w_illegal = 1'b1;
                    end else begin
                        // CSR ops; funct3[2] set means rs1 field is a uimm, not a register
                        w_optype    = DEC_CSR;
                        w_rd_valid  = 1'b1;
                        w_rs1_valid = !w_funct3[2];
                        w_imm_valid = 1'b1;
                        w_imm       = w_imm_z;
                    end
                end
                OPC_FENCE: begin
                    w_optype    = DEC_FENCE;
                    w_imm_valid = 1'b1;
                    w_imm       = w_imm_z;
                    if (w_funct3 > 3'b001)
                        w_illegal = 1'b1;
                end
                default: begin
                    w_illegal = 1'b1;
                end
            endcase
        end

        // x0 writes are architecturally discarded; rename must not allocate for them
        if (w_rd == 5'd0)
            w_rd_valid = 1'b0;

        if (w_illegal) begin
            w_optype    = DEC_ILLEGAL;
            w_rd_valid  = 1'b0;
            w_rs1_valid = 1'b0;
            w_rs2_valid = 1'b0;
            w_imm_valid = 1'b0;
            w_imm       = 32'b0;
        end
    end

    assign o_bundle.optype    = w_optype;
    assign o_bundle.funct3    = w_funct3;
    assign o_bundle.funct7    = w_funct7;
    assign o_bundle.rd        = w_rd;
    assign o_bundle.rs1       = w_rs1;
    assign o_bundle.rs2       = w_rs2;
    assign o_bundle.rd_valid  = w_rd_valid;
    assign o_bundle.rs1_valid = w_rs1_valid;
    assign o_bundle.rs2_valid = w_rs2_valid;
    assign o_bundle.imm_valid = w_imm_valid;
    assign o_bundle.imm       = w_imm;
    assign o_bundle.illegal   = w_illegal;

endmodule

// File: rtl/qu_instr_decoder.sv
// rtl/qu_instr_decoder.sv - Qu decode stage: RV32I decode behind a 2-entry skid buffer
// Ports: clk, rst (sync, active-high), flush (drops held entries)
//        in_valid/in_ready/in_instr/in_pc       fetch side handshake
//        out_valid/out_ready/out_pc/out_*       decoded bundle to rename/RS allocation
// Only INSTR_WIDTH=32 is supported.
import qu_instr_decoder_pkg::*;

module qu_instr_decoder #(
    parameter int PC_WIDTH    = QU_PC_WIDTH,
    parameter int INSTR_WIDTH = QU_INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    input  logic [PC_WIDTH-1:0]    in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [3:0]             out_optype,
    output logic [2:0]             out_funct3,
    output logic [6:0]             out_funct7,
    output logic [4:0]             out_rd,
    output logic [4:0]             out_rs1,
    output logic [4:0]             out_rs2,
    output logic                   out_rd_valid,
    output logic                   out_rs1_valid,
    output logic                   out_rs2_valid,
    output logic                   out_imm_valid,
    output logic [31:0]            out_imm,
    output logic                   out_illegal
);

    dec_bundle_t         w_dec;
    logic                w_accept;

    // M drives the outputs; S catches an accepted word while M is stalled.
    logic                r_m_valid;
    dec_bundle_t         r_m;
    logic [PC_WIDTH-1:0] r_m_pc;
    logic                r_s_valid;
    dec_bundle_t         r_s;
    logic [PC_WIDTH-1:0] r_s_pc;

    qu_instr_decode_comb u_decode (
        .i_instr  (in_instr),
        .o_bundle (w_dec)
    );

    // in_ready depends only on a flop, so it never combinationally follows out_ready.
    assign in_ready = !r_s_valid;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_m       <= '0;
            r_s       <= '0;
            r_m_pc    <= '0;
            r_s_pc    <= '0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else begin
            if (!r_m_valid || out_ready) begin
                // M free or draining: oldest held entry (S) goes first to keep FIFO order.
                // S full implies in_ready=0, so no accept can coincide with the S->M move.
                if (r_s_valid) begin
                    r_m       <= r_s;
                    r_m_pc    <= r_s_pc;
                    r_m_valid <= 1'b1;
                    r_s_valid <= 1'b0;
                end else if (w_accept) begin
                    r_m       <= w_dec;
                    r_m_pc    <= in_pc;
                    r_m_valid <= 1'b1;
                end else begin
                    r_m_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_s       <= w_dec;
                r_s_pc    <= in_pc;
                r_s_valid <= 1'b1;
            end
        end
    end

    assign out_valid     = r_m_valid;
    assign out_pc        = r_m_pc;
    assign out_optype    = r_m.optype;
    assign out_funct3    = r_m.funct3;
    assign out_funct7    = r_m.funct7;
    assign out_rd        = r_m.rd;
    assign out_rs1       = r_m.rs1;
    assign out_rs2       = r_m.rs2;
    assign out_rd_valid  = r_m.rd_valid;
    assign out_rs1_valid = r_m.rs1_valid;
    assign out_rs2_valid = r_m.rs2_valid;
    assign out_imm_valid = r_m.imm_valid;
    assign out_imm       = r_m.imm;
    assign out_illegal   = r_m.illegal;

endmodule

// File: tb/tb_qu_instr_decoder.sv
// tb/tb_qu_instr_decoder.sv - scoreboard bench for qu_instr_decoder
module tb_qu_instr_decoder;

    localparam int NV = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'b0;
    logic [11:0] in_pc = 12'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] out_pc;
    logic [3:0]  out_optype;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic        out_rd_valid;
    logic        out_rs1_valid;
    logic        out_rs2_valid;
    logic        out_imm_valid;
    logic [31:0] out_imm;
    logic        out_illegal;

    int n_checks = 0;
    int n_errors = 0;

    logic [77:0] sb_q[$];
    logic [77:0] exp_cur;
    logic [31:0] instr_tbl[NV];
    logic [11:0] pc_tbl[NV];
    logic [77:0] exp_tbl[NV];
    logic [77:0] w_act;

    qu_instr_decoder dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_optype    (out_optype),
        .out_funct3    (out_funct3),
        .out_funct7    (out_funct7),
        .out_rd        (out_rd),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_rd_valid  (out_rd_valid),
        .out_rs1_valid (out_rs1_valid),
        .out_rs2_valid (out_rs2_valid),
        .out_imm_valid (out_imm_valid),
        .out_imm       (out_imm),
        .out_illegal   (out_illegal)
    );

    always #5 clk = ~clk;

    assign w_act = {out_pc, out_optype, out_funct3, out_funct7, out_rd, out_rs1, out_rs2,
                    out_rd_valid, out_rs1_valid, out_rs2_valid, out_imm_valid, out_imm, out_illegal};

    // v = {rd_valid, rs1_valid, rs2_valid, imm_valid}
    function automatic logic [77:0] mk(input logic [11:0] pc, input logic [3:0] opt,
                                       input logic [2:0] f3, input logic [6:0] f7,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [3:0] v,
                                       input logic [31:0] imm, input logic ill);
        return {pc, opt, f3, f7, rd, rs1, rs2, v, imm, ill};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard push: an accepted input contributes its expected bundle; flush/rst empty it.
    always @(negedge clk) begin
        if (rst || flush)
            sb_q.delete();
        else if (in_valid && in_ready)
            sb_q.push_back(exp_cur);
    end

    // Monitor: every output transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_bundle: got 0x%0h expected none", w_act);
            end else begin
                logic [77:0] e;
                e = sb_q.pop_front();
                if (w_act !== e) begin
                    n_errors++;
                    $display("FAIL bundle pc=0x%0h: got 0x%0h expected 0x%0h", e[77:66], w_act, e);
                end
            end
        end
    end

    task automatic drive(input int i);
        in_instr = instr_tbl[i];
        in_pc    = pc_tbl[i];
        exp_cur  = exp_tbl[i];
        in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        int k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            k++;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send(input int i);
        drive(i);
        wait_accept();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        instr_tbl[0]  = 32'hFFF10093; pc_tbl[0]  = 12'h100; // addi x1,x2,-1
        instr_tbl[1]  = 32'h405201B3; pc_tbl[1]  = 12'h104; // sub x3,x4,x5
        instr_tbl[2]  = 32'hFE208EE3; pc_tbl[2]  = 12'h108; // beq x1,x2,-4
        instr_tbl[3]  = 32'h00000000; pc_tbl[3]  = 12'h10C; // low bits != 11
        instr_tbl[4]  = 32'h02000033; pc_tbl[4]  = 12'h110; // R funct7=0x01
        instr_tbl[5]  = 32'h00832283; pc_tbl[5]  = 12'h114; // lw x5,8(x6)
        instr_tbl[6]  = 32'hFE742C23; pc_tbl[6]  = 12'h118; // sw x7,-8(x8)
        instr_tbl[7]  = 32'h12345537; pc_tbl[7]  = 12'h11C; // lui x10,0x12345
        instr_tbl[8]  = 32'h001000EF; pc_tbl[8]  = 12'h120; // jal x1,+2048
        instr_tbl[9]  = 32'h4051D193; pc_tbl[9]  = 12'h124; // srai x3,x3,5
        instr_tbl[10] = 32'h300312F3; pc_tbl[10] = 12'h128; // csrrw x5,0x300,x6
        instr_tbl[11] = 32'h000000F3; pc_tbl[11] = 12'h12C; // ecall with rd=1
        instr_tbl[12] = 32'h0FF0000F; pc_tbl[12] = 12'h130; // fence iorw,iorw
        instr_tbl[13] = 32'h00009067; pc_tbl[13] = 12'h134; // jalr funct3=001
        instr_tbl[14] = 32'h300352F3; pc_tbl[14] = 12'h138; // csrrwi x5,0x300,6

        exp_tbl[0]  = mk(12'h100, 4'd1,  3'd0, 7'h7F, 5'd1,  5'd2, 5'd31, 4'b1101, 32'hFFFFFFFF, 1'b0);
        exp_tbl[1]  = mk(12'h104, 4'd0,  3'd0, 7'h20, 5'd3,  5'd4, 5'd5,  4'b1110, 32'h0,        1'b0);
        exp_tbl[2]  = mk(12'h108, 4'd4,  3'd0, 7'h7F, 5'd29, 5'd1, 5'd2,  4'b0111, 32'hFFFFFFFC, 1'b0);
        exp_tbl[3]  = mk(12'h10C, 4'd15, 3'd0, 7'h00, 5'd0,  5'd0, 5'd0,  4'b0000, 32'h0,        1'b1);
        exp_tbl[4]  = mk(12'h110, 4'd15, 3'd0, 7'h01, 5'd0,  5'd0, 5'd0,  4'b0000, 32'h0,        1'b1);
        exp_tbl[5]  = mk(12'h114, 4'd2,  3'd2, 7'h00, 5'd5,  5'd6, 5'd8,  4'b1101, 32'h8,        1'b0);
        exp_tbl[6]  = mk(12'h118, 4'd3,  3'd2, 7'h7F, 5'd24, 5'd8, 5'd7,  4'b0111, 32'hFFFFFFF8, 1'b0);
        exp_tbl[7]  = mk(12'h11C, 4'd7,  3'd5, 7'h09, 5'd10, 5'd8, 5'd3,  4'b1001, 32'h12345000, 1'b0);
        exp_tbl[8]  = mk(12'h120, 4'd5,  3'd0, 7'h00, 5'd1,  5'd0, 5'd1,  4'b1001, 32'h800,      1'b0);
        exp_tbl[9]  = mk(12'h124, 4'd1,  3'd5, 7'h20, 5'd3,  5'd3, 5'd5,  4'b1101, 32'h5,        1'b0);
        exp_tbl[10] = mk(12'h128, 4'd10, 3'd1, 7'h18, 5'd5,  5'd6, 5'd0,  4'b1101, 32'h300,      1'b0);
        exp_tbl[11] = mk(12'h12C, 4'd15, 3'd0, 7'h00, 5'd1,  5'd0, 5'd0,  4'b0000, 32'h0,        1'b1);
        exp_tbl[12] = mk(12'h130, 4'd11, 3'd0, 7'h07, 5'd0,  5'd0, 5'd31, 4'b0001, 32'hFF,       1'b0);
        exp_tbl[13] = mk(12'h134, 4'd15, 3'd1, 7'h00, 5'd0,  5'd1, 5'd0,  4'b0000, 32'h0,        1'b1);
        exp_tbl[14] = mk(12'h138, 4'd10, 3'd5, 7'h18, 5'd5,  5'd6, 5'd0,  4'b1001, 32'h300,      1'b0);
        exp_cur = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_imm", out_imm, 32'd0);
        chk("reset_out_optype", 32'(out_optype), 32'd0);
        chk("reset_out_pc", 32'(out_pc), 32'd0);

        // Back-to-back decode of every vector with no backpressure
        @(posedge clk);
        #1;
        for (int i = 0; i < NV; i++) send(i);
        repeat (3) @(posedge clk);
        #1 chk("stream_drained", 32'(sb_q.size()), 32'd0);

        // Backpressure: A, B accepted, C held off until the stall releases
        out_ready = 1'b0;
        send(0);
        send(1);
        drive(2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_pc", 32'(out_pc), 32'(pc_tbl[0]));
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_accept();
        repeat (4) @(posedge clk);
        #1 chk("bp_drained", 32'(sb_q.size()), 32'd0);

        // Flush with M and S full and in_valid high
        out_ready = 1'b0;
        send(5);
        send(6);
        drive(7);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (4) @(posedge clk);

        // Flush while an input is actually being accepted
        #1 out_ready = 1'b0;
        send(5);
        drive(6);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_acc_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (4) @(posedge clk);

        // Reset mid-stream with M and S full
        #1 out_ready = 1'b0;
        send(8);
        send(9);
        drive(10);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_imm", out_imm, 32'd0);
        chk("rst_out_pc", 32'(out_pc), 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_optype", 32'(out_optype), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (4) @(posedge clk);

        // Decoder still works normally after flush/reset
        #1 send(14);
        repeat (4) @(posedge clk);
        #1 chk("final_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
